load_store_unit: RTL and testbench
==================================

# load_store_unit

- Sits between the execute stage and `data_memory` in the 16-bit processor.
- Takes load/store requests from execute over a valid/ready handshake and forms the word address as base + signed offset.
- Stores go into a small in-order store buffer that drains into memory one per cycle. Loads forward from that buffer when addresses match.
- Load results return to writeback with fixed one-cycle latency; out-of-range addresses raise a fault.

## Interface
Parameters:
- `ADDR_W`, 6, word-address width of data memory (64 words).
- `DATA_W`, 16, data word width.
- `SB_DEPTH`, 2, store buffer entries.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clock_enable`  in  1  global pipeline enable; 0 freezes all state.
- `req_valid`  in  1  execute presents a request.
- `req_ready`  out  1  request accepted at this edge when `req_valid & req_ready & clock_enable`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_base`  in  16  base register value.
- `req_offset`  in  8  signed immediate offset.
- `req_wdata`  in  16  store data.
- `req_rd`  in  3  load destination register tag.
- `drain_hold`  in  1  halt/debug controller blocks store draining.
- `resp_valid`  out  1  load result valid.
- `resp_rd`  out  3  tag of returned load.
- `resp_data`  out  16  load data.
- `fault`  out  1  one-cycle pulse: out-of-range access.
- `fault_addr`  out  16  effective address of the faulting access.
- `sb_empty`  out  1  store buffer holds no entries.
- `mem_read_address`  out  6  to memory read port.
- `mem_read_enable`  out  1  to memory.
- `mem_write_address`  out  6  to memory write port.
- `mem_write_enable`  out  1  to memory.
- `mem_data_in`  out  16  store data to memory.
- `mem_data_out`  in  16  combinational read data from memory.

## Operation
- Effective address: EA = `req_base` + sign-extended `req_offset`, computed mod 2^16.
  - In range iff EA[15:6] == 0. Word address = EA[5:0].
- `req_ready` = (count < `SB_DEPTH`), using the count at start of cycle. It ignores any same-cycle drain.
- Out-of-range request:
  - Accepted normally, but has no memory effect and no buffer entry.
  - `fault`=1 and `fault_addr`=EA on the next enabled cycle; no `resp_valid`.
- Load, in range:
  - `mem_read_address`=EA[5:0] and `mem_read_enable`=1, combinationally while `req_valid & !req_store`.
  - At acceptance, data is captured from the youngest valid buffer entry whose address equals EA[5:0]; otherwise from `mem_data_out`.
  - An entry draining in the same cycle still counts for forwarding.
- Store, in range: written at the buffer tail, with address and data.
- Drain:
  - When count > 0, `!drain_hold` and `clock_enable`, the head is presented on `mem_write_*` combinationally.
  - Memory writes it at the edge and the head pops at that same edge.
  - Push and pop in one cycle are both allowed.
- Buffer is strict FIFO; head/tail pointers wrap modulo `SB_DEPTH`.
- `sb_empty` = (count == 0).

## Timing
- Load latency: exactly 1 enabled cycle. `resp_valid` is high for one enabled cycle after acceptance, with `resp_rd` and `resp_data`.
- Store visibility:
  - Stores are visible to later loads immediately, via forwarding.
  - Stores reach memory at the earliest 1 edge after acceptance, later under `drain_hold`.
- `clock_enable`=0:
  - No acceptance, no drain, `mem_write_enable`=0.
  - All registers, including `resp_valid` and `fault`, hold. Downstream stalls on the same enable.
- Reset values: count=0, pointers=0, `resp_valid`=0, `resp_rd`=0, `resp_data`=0, `fault`=0, `fault_addr`=0, `sb_empty`=1.
- Reset mid-operation discards buffered stores unwritten and cancels any pending response.
- Full buffer with `drain_hold`=1: `req_ready`=0 for loads and stores alike until a drain occurs.

## Structure
- Shared package `lsu_pkg`:
  - `ADDR_W`, `DATA_W`, `SB_DEPTH`.
  - Store-buffer entry typedef {valid, addr[5:0], data[15:0]}.
  - The in-range check function.
- One sub-module, `store_buffer`: FIFO with push/pop, count, and an address-match forwarding lookup that returns the youngest hit.
- The top level holds EA arithmetic, the handshake, and the response/fault registers.

## Test plan
- Load, base=0x0010, offset=+5, memory[21]=0xBEEF → next cycle `resp_valid`=1, `resp_data`=0xBEEF, correct `resp_rd`.
- Store 0x1234 to word 7, then a load of word 7 on the immediately following cycle → `resp_data`=0x1234 (forwarded). Memory[7]=0x1234 after drain.
- `drain_hold`=1 with stores to 3 then 4 → `req_ready`=0 after second acceptance. Release hold → writes occur in order, one per cycle, and `sb_empty` rises after 2 cycles.
- Two stores to the same word (0xAAAA then 0x5555) under hold, then a load → 0x5555 returned. Final memory value = 0x5555.
- base=0x003F, offset=+1 (EA=0x0040) → `fault` pulse with `fault_addr`=0x0040, no write, no `resp_valid`. base=0x0002, offset=−3 → fault with `fault_addr`=0xFFFF.
- Hold `clock_enable`=0 for 3 cycles with a pending response, then assert `reset_n`=0 with a buffered store → response frozen until reset, store never written, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory geometry, store-buffer
// entry layout and the address range check.
package lsu_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;
    localparam int SB_DEPTH = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // Only the low ADDR_W bits of an effective address may be non-zero.
    function automatic logic addr_in_range(input logic [15:0] ea);
        return ea[15:ADDR_W] == '0;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// In-order store buffer: FIFO of pending stores with a youngest-match
// forwarding lookup for loads.
module store_buffer
    import lsu_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic [CNT_W-1:0]  count_o,
    output sb_entry_t         head_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W-1:0]      lk_idx;
    logic [CNT_W-1:0]      count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop_i) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = ptr_inc(head_q);
        end
        if (push_i) begin
            entries_d[tail_q] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
            tail_d            = ptr_inc(tail_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk from head (oldest) to youngest so the last hit wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        lk_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = PTR_W'((int'(head_q) + i) % DEPTH);
            if (entries_q[lk_idx].valid && entries_q[lk_idx].addr == lookup_addr_i) begin
                hit_o      = 1'b1;
                hit_data_o = entries_q[lk_idx].data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entries_q[head_q];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: effective-address formation, request handshake, store
// buffer drain to data memory and the one-cycle load response / fault path.
module load_store_unit #(
    parameter int ADDR_W   = lsu_pkg::ADDR_W,
    parameter int DATA_W   = lsu_pkg::DATA_W,
    parameter int SB_DEPTH = lsu_pkg::SB_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clock_enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [15:0]       req_base,
    input  logic [7:0]        req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_rd,
    input  logic              drain_hold,
    output logic              resp_valid,
    output logic [2:0]        resp_rd,
    output logic [DATA_W-1:0] resp_data,
    output logic              fault,
    output logic [15:0]       fault_addr,
    output logic              sb_empty,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    import lsu_pkg::*;

    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    logic [15:0]       ea;
    logic              ea_ok;
    logic              accept;
    logic              drain;
    logic              push;
    logic              load_ok;
    logic [CNT_W-1:0]  sb_count;
    sb_entry_t         sb_head;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    logic              resp_valid_q, resp_valid_d;
    logic [2:0]        resp_rd_q, resp_rd_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              fault_q, fault_d;
    logic [15:0]       fault_addr_q, fault_addr_d;

    assign ea     = req_base + {{8{req_offset[7]}}, req_offset};
    assign ea_ok  = addr_in_range(ea);

    // Readiness uses the start-of-cycle count; a same-cycle drain does not help.
    assign req_ready = (sb_count < CNT_W'(SB_DEPTH));
    assign accept    = req_valid & req_ready & clock_enable;
    assign push      = accept & req_store & ea_ok;
    assign load_ok   = accept & ~req_store & ea_ok;
    assign drain     = sb_head.valid & ~drain_hold & clock_enable;

    store_buffer #(.DEPTH(SB_DEPTH)) u_store_buffer (
        .clk           (clk),
        .reset_n       (reset_n),
        .push_i        (push),
        .push_addr_i   (ea[ADDR_W-1:0]),
        .push_data_i   (req_wdata),
        .pop_i         (drain),
        .lookup_addr_i (ea[ADDR_W-1:0]),
        .count_o       (sb_count),
        .head_o        (sb_head),
        .hit_o         (fwd_hit),
        .hit_data_o    (fwd_data)
    );

    assign mem_read_address  = ea[ADDR_W-1:0];
    assign mem_read_enable   = req_valid & ~req_store & ea_ok;
    assign mem_write_address = sb_head.addr;
    assign mem_data_in       = sb_head.data;
    assign mem_write_enable  = drain;
    assign sb_empty          = (sb_count == '0);

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rd_d    = resp_rd_q;
        resp_data_d  = resp_data_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (clock_enable) begin
            resp_valid_d = load_ok;
            fault_d      = accept & ~ea_ok;
            if (load_ok) begin
                resp_rd_d   = req_rd;
                resp_data_d = fwd_hit ? fwd_data : mem_data_out;
            end
            if (accept && !ea_ok) begin
                fault_addr_d = ea;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus a random
// run against a program-order memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        clock_enable;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [15:0] req_base;
    logic [7:0]  req_offset;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic        drain_hold;
    logic        resp_valid;
    logic [2:0]  resp_rd;
    logic [15:0] resp_data;
    logic        fault;
    logic [15:0] fault_addr;
    logic        sb_empty;
    logic [5:0]  mem_read_address;
    logic        mem_read_enable;
    logic [5:0]  mem_write_address;
    logic        mem_write_enable;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [64];

    load_store_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clock_enable      (clock_enable),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_store         (req_store),
        .req_base          (req_base),
        .req_offset        (req_offset),
        .req_wdata         (req_wdata),
        .req_rd            (req_rd),
        .drain_hold        (drain_hold),
        .resp_valid        (resp_valid),
        .resp_rd           (resp_rd),
        .resp_data         (resp_data),
        .fault             (fault),
        .fault_addr        (fault_addr),
        .sb_empty          (sb_empty),
        .mem_read_address  (mem_read_address),
        .mem_read_enable   (mem_read_enable),
        .mem_write_address (mem_write_address),
        .mem_write_enable  (mem_write_enable),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_read_address];
    always @(posedge clk) begin
        if (mem_write_enable === 1'b1) mem[mem_write_address] <= mem_data_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_base   = '0;
        req_offset = '0;
        req_wdata  = '0;
        req_rd     = '0;
    endtask

    task automatic drive_req(input logic st, input logic [15:0] b, input logic [7:0] o,
                             input logic [15:0] wd, input logic [2:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_base   = b;
        req_offset = o;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%0b exp=0", fault); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty got=%0b exp=1", sb_empty); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%0b exp=0", mem_write_enable); end
        checks++; if (resp_data !== 16'h0 || fault_addr !== 16'h0) begin errors++; $display("FAIL reset_regs got data=%h faddr=%h exp 0", resp_data, fault_addr); end
    endtask

    task automatic test_load();
        mem[21] = 16'hBEEF;
        drive_req(1'b0, 16'h0010, 8'd5, 16'h0, 3'd3);
        #1;
        checks++; if (mem_read_enable !== 1'b1 || mem_read_address !== 6'd21) begin errors++; $display("FAIL load_read_port got en=%0b addr=%0d exp en=1 addr=21", mem_read_enable, mem_read_address); end
        tick();
        drive_idle();
        #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL load_resp_valid got=%0b exp=1", resp_valid); end
        checks++; if (resp_data !== 16'hBEEF) begin errors++; $display("FAIL load_resp_data got=%h exp=beef", resp_data); end
        checks++; if (resp_rd !== 3'd3) begin errors++; $display("FAIL load_resp_rd got=%0d exp=3", resp_rd); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL load_resp_pulse got=%0b exp=0", resp_valid); end
    endtask

    task automatic test_forward();
        mem[7] = 16'h0000;
        drive_req(1'b1, 16'h0007, 8'd0, 16'h1234, 3'd0);
        tick();
        drive_req(1'b0, 16'h0007, 8'd0, 16'h0, 3'd5);
        #1;
        checks++; if (mem_write_enable !== 1'b1 || mem_write_address !== 6'd7) begin errors++; $display("FAIL fwd_drain got en=%0b addr=%0d exp en=1 addr=7", mem_write_enable, mem_write_address); end
        tick();
        drive_idle();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 16'h1234 || resp_rd !== 3'd5) begin errors++; $display("FAIL fwd_resp got v=%0b data=%h rd=%0d exp v=1 data=1234 rd=5", resp_valid, resp_data, resp_rd); end
        checks++; if (mem[7] !== 16'h1234) begin errors++; $display("FAIL fwd_mem7 got=%h exp=1234", mem[7]); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_sb_empty got=%0b exp=1", sb_empty); end
        tick();
    endtask

    task automatic test_drain_hold();
        mem[3] = 16'h0;
        mem[4] = 16'h0;
        drain_hold = 1'b1;
        drive_req(1'b1, 16'h0003, 8'd0, 16'h0303, 3'd0);
        tick();
        drive_req(1'b1, 16'h0004, 8'd0, 16'h0404, 3'd0);
        tick();
        drive_req(1'b0, 16'h000A, 8'd0, 16'h0, 3'd1);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%0b exp=0", req_ready); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL hold_no_write got=%0b exp=0", mem_write_enable); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL hold_load_blocked got=%0b exp=0", resp_valid); end
        drive_idle();
        drain_hold = 1'b0;
        #1;
        checks++; if (mem_write_enable !== 1'b1 || mem_write_address !== 6'd3 || mem_data_in !== 16'h0303) begin errors++; $display("FAIL drain_first got en=%0b addr=%0d data=%h exp 1/3/0303", mem_write_enable, mem_write_address, mem_data_in); end
        tick();
        checks++; if (mem_write_enable !== 1'b1 || mem_write_address !== 6'd4 || mem_data_in !== 16'h0404 || sb_empty !== 1'b0) begin errors++; $display("FAIL drain_second got en=%0b addr=%0d data=%h empty=%0b exp 1/4/0404/0", mem_write_enable, mem_write_address, mem_data_in, sb_empty); end
        tick();
        checks++; if (sb_empty !== 1'b1 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL drain_done got empty=%0b we=%0b exp 1/0", sb_empty, mem_write_enable); end
        checks++; if (mem[3] !== 16'h0303 || mem[4] !== 16'h0404) begin errors++; $display("FAIL drain_mem got m3=%h m4=%h exp 0303/0404", mem[3], mem[4]); end
    endtask

    task automatic test_same_word();
        logic accepted;
        accepted = 1'b0;
        mem[9] = 16'h0;
        drain_hold = 1'b1;
        drive_req(1'b1, 16'h0009, 8'd0, 16'hAAAA, 3'd0);
        tick();
        drive_req(1'b1, 16'h0009, 8'd0, 16'h5555, 3'd0);
        tick();
        drain_hold = 1'b0;
        drive_req(1'b0, 16'h0009, 8'd0, 16'h0, 3'd6);
        for (int k = 0; k < 6; k++) begin
            #1;
            if (req_ready === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!accepted) begin errors++; $display("FAIL same_word_ready got=timeout exp=ready within 6 cycles"); end
        tick();
        drive_idle();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 16'h5555 || resp_rd !== 3'd6) begin errors++; $display("FAIL same_word_resp got v=%0b data=%h rd=%0d exp 1/5555/6", resp_valid, resp_data, resp_rd); end
        for (int k = 0; k < 6 && sb_empty !== 1'b1; k++) tick();
        checks++; if (sb_empty !== 1'b1 || mem[9] !== 16'h5555) begin errors++; $display("FAIL same_word_mem got empty=%0b m9=%h exp 1/5555", sb_empty, mem[9]); end
    endtask

    task automatic test_fault();
        drive_req(1'b1, 16'h003F, 8'd1, 16'hDEAD, 3'd0);
        tick();
        drive_idle();
        #1;
        checks++; if (fault !== 1'b1 || fault_addr !== 16'h0040) begin errors++; $display("FAIL fault_hi got f=%0b addr=%h exp 1/0040", fault, fault_addr); end
        checks++; if (resp_valid !== 1'b0 || sb_empty !== 1'b1 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL fault_hi_effect got v=%0b empty=%0b we=%0b exp 0/1/0", resp_valid, sb_empty, mem_write_enable); end
        tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_pulse got=%0b exp=0", fault); end
        drive_req(1'b0, 16'h0002, 8'hFD, 16'h0, 3'd2);
        #1;
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL fault_lo_read got=%0b exp=0", mem_read_enable); end
        tick();
        drive_idle();
        #1;
        checks++; if (fault !== 1'b1 || fault_addr !== 16'hFFFF || resp_valid !== 1'b0) begin errors++; $display("FAIL fault_lo got f=%0b addr=%h v=%0b exp 1/ffff/0", fault, fault_addr, resp_valid); end
        tick();
    endtask

    task automatic test_ce_reset();
        mem[12] = 16'h0000;
        mem[21] = 16'hCAFE;
        drain_hold = 1'b1;
        drive_req(1'b1, 16'h000C, 8'd0, 16'h7777, 3'd0);
        tick();
        drive_req(1'b0, 16'h0015, 8'd0, 16'h0, 3'd4);
        tick();
        drive_idle();
        clock_enable = 1'b0;
        drain_hold   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_data !== 16'hCAFE || resp_rd !== 3'd4) begin errors++; $display("FAIL ce_freeze_resp cyc=%0d got v=%0b data=%h rd=%0d exp 1/cafe/4", k, resp_valid, resp_data, resp_rd); end
            checks++; if (mem_write_enable !== 1'b0 || sb_empty !== 1'b0) begin errors++; $display("FAIL ce_freeze_sb cyc=%0d got we=%0b empty=%0b exp 0/0", k, mem_write_enable, sb_empty); end
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || resp_rd !== 3'd0 || resp_data !== 16'h0) begin errors++; $display("FAIL rst_resp got v=%0b rd=%0d data=%h exp 0/0/0", resp_valid, resp_rd, resp_data); end
        checks++; if (fault !== 1'b0 || fault_addr !== 16'h0 || sb_empty !== 1'b1 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_state got f=%0b faddr=%h empty=%0b we=%0b exp 0/0/1/0", fault, fault_addr, sb_empty, mem_write_enable); end
        tick();
        clock_enable = 1'b1;
        reset_n      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_no_write cyc=%0d got=%0b exp=0", k, mem_write_enable); end
            tick();
        end
        checks++; if (mem[12] !== 16'h0000) begin errors++; $display("FAIL rst_discard got m12=%h exp=0000", mem[12]); end
    endtask

    task automatic test_random();
        logic [15:0] arch [64];
        logic [5:0]  qa [$];
        logic [15:0] qd [$];
        logic        exp_rv, exp_f, exp_ready, exp_drain, acc, v, st, nrv, nf;
        logic [2:0]  exp_rd, rd;
        logic [15:0] exp_data, exp_fa, base, wd, ea;
        logic [7:0]  off;
        int          diffs;
        exp_rv = 1'b0; exp_f = 1'b0; exp_rd = '0; exp_data = '0; exp_fa = '0;
        drive_idle();
        clock_enable = 1'b1;
        drain_hold   = 1'b0;
        reset_n      = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 64; i++) arch[i] = mem[i];
        for (int n = 0; n < 800; n++) begin
            v    = ($urandom_range(0, 9) < 7);
            st   = 1'($urandom_range(0, 1));
            base = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            off  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12)) - 8'd4;
            wd   = 16'($urandom);
            rd   = 3'($urandom_range(0, 7));
            req_valid    = v;
            req_store    = st;
            req_base     = base;
            req_offset   = off;
            req_wdata    = wd;
            req_rd       = rd;
            clock_enable = ($urandom_range(0, 7) != 0);
            drain_hold   = ($urandom_range(0, 3) == 0);
            #1;
            ea        = 16'(int'(base) + int'($signed(off)));
            exp_ready = (qa.size() < 2);
            exp_drain = (qa.size() > 0) && !drain_hold && clock_enable;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, req_ready, exp_ready); end
            checks++; if (mem_write_enable !== exp_drain) begin errors++; $display("FAIL rnd_we n=%0d got=%0b exp=%0b", n, mem_write_enable, exp_drain); end
            if (exp_drain) begin
                checks++; if (mem_write_address !== qa[0] || mem_data_in !== qd[0]) begin errors++; $display("FAIL rnd_drain n=%0d got addr=%0d data=%h exp addr=%0d data=%h", n, mem_write_address, mem_data_in, qa[0], qd[0]); end
            end
            checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL rnd_resp_valid n=%0d got=%0b exp=%0b", n, resp_valid, exp_rv); end
            if (exp_rv) begin
                checks++; if (resp_rd !== exp_rd || resp_data !== exp_data) begin errors++; $display("FAIL rnd_resp n=%0d got rd=%0d data=%h exp rd=%0d data=%h", n, resp_rd, resp_data, exp_rd, exp_data); end
            end
            checks++; if (fault !== exp_f) begin errors++; $display("FAIL rnd_fault n=%0d got=%0b exp=%0b", n, fault, exp_f); end
            if (exp_f) begin
                checks++; if (fault_addr !== exp_fa) begin errors++; $display("FAIL rnd_fault_addr n=%0d got=%h exp=%h", n, fault_addr, exp_fa); end
            end
            checks++; if (sb_empty !== (qa.size() == 0)) begin errors++; $display("FAIL rnd_sb_empty n=%0d got=%0b exp=%0b", n, sb_empty, qa.size() == 0); end
            checks++; if (mem_read_enable !== (v && !st && ea < 16'd64)) begin errors++; $display("FAIL rnd_read_en n=%0d got=%0b exp=%0b", n, mem_read_enable, v && !st && ea < 16'd64); end
            if (clock_enable) begin
                acc = v && exp_ready;
                nrv = 1'b0;
                nf  = 1'b0;
                if (exp_drain) begin
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                if (acc) begin
                    if (ea >= 16'd64) begin
                        nf     = 1'b1;
                        exp_fa = ea;
                    end else if (st) begin
                        arch[ea[5:0]] = wd;
                        qa.push_back(ea[5:0]);
                        qd.push_back(wd);
                    end else begin
                        nrv      = 1'b1;
                        exp_rd   = rd;
                        exp_data = arch[ea[5:0]];
                    end
                end
                exp_rv = nrv;
                exp_f  = nf;
            end
            tick();
        end
        drive_idle();
        clock_enable = 1'b1;
        drain_hold   = 1'b0;
        for (int k = 0; k < 6 && sb_empty !== 1'b1; k++) tick();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rnd_final_empty got=%0b exp=1", sb_empty); end
        diffs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== arch[i]) diffs++;
        checks++; if (diffs != 0) begin errors++; $display("FAIL rnd_final_mem got %0d differing words exp 0", diffs); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        reset_n      = 1'b0;
        clock_enable = 1'b1;
        drain_hold   = 1'b0;
        drive_idle();
        tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_load();
        test_forward();
        test_drain_hold();
        test_same_word();
        test_fault();
        test_ce_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
